// File: rtl/cam_init_seq.sv
// Camera init command sequencer: walks an {addr,data} init ROM, then hands the SCCB command port to the host.
// Latency: 2-cycle ROM fetch per entry, then one command per downstream response; host path is combinational out, 1-cycle registered response.
// Backpressure: rw_cmd held stable until rw_cmd_ready; host_cmd_ready mirrors rw_cmd_ready only while the host owns the port.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, (re)starts the init walk from entry 0
//   rom_addr/rom_data   init ROM; rom_data is valid one cycle after rom_addr changes
//   rw_cmd*/rw_resp*    downstream register-access command/response ({rw, addr, data}, rw=1 write)
//   host_cmd*/host_resp* runtime passthrough, active only in IDLE after a completed walk
//   busy, done, err_cnt status; err_cnt counts readback mismatches (saturating)
//
// Optional build macro CAM_INIT_VERIFY_EN: read back every written register (except
// delay entries 16'hF0F0), retry mismatching writes up to MAX_RETRY times and count
// mismatches in err_cnt. Without it, err_cnt is tied to zero.

module cam_init_seq #(
    parameter int          ROM_AW    = 8,
    parameter logic [15:0] END_WORD  = 16'hFFFF,
    parameter int          MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [16:0]       rw_cmd,
    output logic              rw_cmd_valid,
    input  logic              rw_cmd_ready,
    input  logic [16:0]       rw_resp,
    input  logic              rw_resp_valid,
    input  logic [16:0]       host_cmd,
    input  logic              host_cmd_valid,
    output logic              host_cmd_ready,
    output logic [16:0]       host_resp,
    output logic              host_resp_valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
`ifdef CAM_INIT_VERIFY_EN
    localparam logic [2:0] S_VISSUE = 3'd6;
    localparam logic [2:0] S_VWAIT  = 3'd7;

    // Delay entries are executed downstream and have no register to read back.
    localparam logic [15:0] DELAY_WORD = 16'hF0F0;
    localparam int          RC_W       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`endif

    logic [2:0]  state;
    logic [15:0] entry;       // current {reg_addr, reg_data} being issued
    logic        fetch_wait;  // first FETCH cycle: ROM output not yet valid
    logic        host_owns;   // passthrough window: idle after a completed walk

`ifdef CAM_INIT_VERIFY_EN
    logic [RC_W-1:0] retry_cnt;
    logic            rb_match;

    assign rb_match = (rw_resp[7:0] == entry[7:0]);
`else
    // MAX_RETRY only matters to the verify build.
    logic unused_cfg;
    assign unused_cfg = ^MAX_RETRY;
    assign err_cnt    = 8'd0;
`endif

    assign host_owns = (state == S_IDLE) && done;

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            entry      <= 16'h0000;
            fetch_wait <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A start while done=1 lands here too: done clears and the walk restarts.
                    if (start) begin
                        rom_addr   <= '0;
                        fetch_wait <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (!fetch_wait) begin
                        fetch_wait <= 1'b1;
                    end else begin
                        fetch_wait <= 1'b0;
                        entry      <= rom_data;
                        state      <= (rom_data == END_WORD) ? S_DONE : S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (rw_cmd_ready) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (rw_resp_valid) begin
`ifdef CAM_INIT_VERIFY_EN
                        state <= (entry != DELAY_WORD) ? S_VISSUE : S_NEXT;
`else
                        state <= S_NEXT;
`endif
                    end
                end

`ifdef CAM_INIT_VERIFY_EN
                S_VISSUE: begin
                    if (rw_cmd_ready) begin
                        state <= S_VWAIT;
                    end
                end

                S_VWAIT: begin
                    if (rw_resp_valid) begin
                        if (rb_match || (int'(retry_cnt) >= MAX_RETRY)) begin
                            state <= S_NEXT;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
`endif

                S_NEXT: begin
                    // A full table with no terminator still completes once the
                    // last address has been issued.
                    if (&rom_addr) begin
                        state <= S_DONE;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        state    <= S_FETCH;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CAM_INIT_VERIFY_EN
    // ------------------------------------------------------------------
    // Readback retry counter and mismatch count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= '0;
            err_cnt   <= 8'd0;
        end else if ((state == S_IDLE) && start) begin
            retry_cnt <= '0;
        end else if ((state == S_VWAIT) && rw_resp_valid) begin
            if (rb_match) begin
                retry_cnt <= '0;
            end else begin
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
                // Out of retries: the sequencer advances, so the count restarts.
                if (int'(retry_cnt) >= MAX_RETRY) begin
                    retry_cnt <= '0;
                end else begin
                    retry_cnt <= retry_cnt + 1'b1;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Command port mux: sequencer during the walk, host afterwards
    // ------------------------------------------------------------------
    always_comb begin
        rw_cmd         = 17'h0;
        rw_cmd_valid   = 1'b0;
        host_cmd_ready = 1'b0;
        case (state)
            S_ISSUE: begin
                rw_cmd       = {1'b1, entry};
                rw_cmd_valid = 1'b1;
            end
`ifdef CAM_INIT_VERIFY_EN
            S_VISSUE: begin
                rw_cmd       = {1'b0, entry[15:8], 8'h00};
                rw_cmd_valid = 1'b1;
            end
`endif
            S_IDLE: begin
                if (done) begin
                    rw_cmd         = host_cmd;
                    rw_cmd_valid   = host_cmd_valid;
                    host_cmd_ready = rw_cmd_ready;
                end
            end
            default: begin
                rw_cmd         = 17'h0;
                rw_cmd_valid   = 1'b0;
                host_cmd_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Host response forward: only responses that arrive while the host owns
    // the port are passed on, so init traffic never reaches the host.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_resp       <= 17'h0;
            host_resp_valid <= 1'b0;
        end else begin
            host_resp_valid <= host_owns && rw_resp_valid;
            if (host_owns && rw_resp_valid) begin
                host_resp <= rw_resp;
            end
        end
    end

endmodule

// File: tb/tb_cam_init_seq.sv
// Self-checking bench for cam_init_seq: table-driven init walks, randomized walks
// against a table-walk reference model, stall, host passthrough, reset and wrap cases.
// Downstream is a behavioural register file with configurable ready and response delay.

module tb_cam_init_seq;

    localparam int ROM_AW = 8;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [16:0]       rw_cmd;
    logic              rw_cmd_valid;
    logic              rw_cmd_ready;
    logic [16:0]       rw_resp;
    logic              rw_resp_valid;
    logic [16:0]       host_cmd;
    logic              host_cmd_valid;
    logic              host_cmd_ready;
    logic [16:0]       host_resp;
    logic              host_resp_valid;
    logic              busy;
    logic              done;
    logic [7:0]        err_cnt;

    cam_init_seq #(
        .ROM_AW   (ROM_AW),
        .END_WORD (16'hFFFF),
        .MAX_RETRY(3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rw_cmd         (rw_cmd),
        .rw_cmd_valid   (rw_cmd_valid),
        .rw_cmd_ready   (rw_cmd_ready),
        .rw_resp        (rw_resp),
        .rw_resp_valid  (rw_resp_valid),
        .host_cmd       (host_cmd),
        .host_cmd_valid (host_cmd_valid),
        .host_cmd_ready (host_cmd_ready),
        .host_resp      (host_resp),
        .host_resp_valid(host_resp_valid),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] rom [256];
    logic [7:0]  mem [256];
    logic [16:0] hs_log [$];
    logic [16:0] wr_q [$];
    logic [16:0] rd_q [$];
    logic [16:0] exp_q [$];
    int          ready_mode = 0;   // 0: always ready, 1: random, 2: never
    int          resp_delay = 2;
    bit          rd_zero = 1'b0;   // downstream returns 0x00 for every read

    typedef struct {
        logic [15:0] img  [4];
        int          n;
        logic [16:0] expv [4];
    } vec_t;

    // ROM with one cycle of latency from address to data.
    initial begin : rom_model
        logic [ROM_AW-1:0] a;
        rom_data = 16'h0000;
        forever begin
            @(negedge clk);
            a = rom_addr;
            @(posedge clk);
            #1;
            rom_data = rom[a];
        end
    end

    // Downstream register-access block: logs every handshake, returns one response.
    initial begin : downstream
        bit          pend;
        int          pend_cnt;
        logic [16:0] pend_resp;
        pend          = 1'b0;
        pend_cnt      = 0;
        pend_resp     = 17'h0;
        rw_cmd_ready  = 1'b0;
        rw_resp       = 17'h0;
        rw_resp_valid = 1'b0;
        foreach (mem[i]) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && rw_cmd_valid && rw_cmd_ready) begin
                hs_log.push_back(rw_cmd);
                if (rw_cmd[16]) begin
                    mem[rw_cmd[15:8]] = rw_cmd[7:0];
                    pend_resp = rw_cmd;
                end else begin
                    pend_resp = {1'b0, rw_cmd[15:8], rd_zero ? 8'h00 : mem[rw_cmd[15:8]]};
                end
                pend     = 1'b1;
                pend_cnt = resp_delay;
            end
            @(posedge clk);
            #1;
            rw_resp_valid = 1'b0;
            case (ready_mode)
                0:       rw_cmd_ready = 1'b1;
                1:       rw_cmd_ready = 1'($urandom_range(0, 1));
                default: rw_cmd_ready = 1'b0;
            endcase
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    rw_resp       = pend_resp;
                    rw_resp_valid = 1'b1;
                    pend          = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rom_addr"},  32'(rom_addr), 32'h0);
        chk({tag, "_rw_cmd"},    32'(rw_cmd), 32'h0);
        chk({tag, "_cmd_valid"}, 32'(rw_cmd_valid), 32'h0);
        chk({tag, "_host_rdy"},  32'(host_cmd_ready), 32'h0);
        chk({tag, "_host_resp"}, 32'(host_resp), 32'h0);
        chk({tag, "_hresp_vld"}, 32'(host_resp_valid), 32'h0);
        chk({tag, "_busy"},      32'(busy), 32'h0);
        chk({tag, "_done"},      32'(done), 32'h0);
        chk({tag, "_err_cnt"},   32'(err_cnt), 32'h0);
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        hs_log.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done; optionally pulses start once mid-walk (must be ignored).
    task automatic wait_done(input int poke_at);
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) break;
            if (c == poke_at) start = 1'b1;
        end
        chk("walk_done", 32'(done), 32'h1);
        chk("walk_busy", 32'(busy), 32'h0);
    endtask

    // Reference: every entry up to the terminator (or the whole table) is written once.
    task automatic build_model();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 16'hFFFF) break;
            exp_q.push_back({1'b1, rom[i]});
        end
    endtask

    task automatic split_log();
        wr_q.delete();
        rd_q.delete();
        foreach (hs_log[i]) begin
            if (hs_log[i][16]) wr_q.push_back(hs_log[i]);
            else               rd_q.push_back(hs_log[i]);
        end
    endtask

    task automatic check_log(input string tag);
        int exp_rd;
        split_log();
        chk({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            chk({tag, "_wr"}, 32'(wr_q[i]), 32'(exp_q[i]));
        exp_rd = 0;
`ifdef CAM_INIT_VERIFY_EN
        foreach (exp_q[i]) if (exp_q[i][15:0] != 16'hF0F0) exp_rd++;
`endif
        chk({tag, "_nrd"}, 32'(rd_q.size()), 32'(exp_rd));
        chk({tag, "_err"}, 32'(err_cnt), 32'h0);
    endtask

    initial begin : test
        vec_t        vecs [4];
        logic [16:0] cmd0;
        logic [7:0]  a0;
        bit          bad_v, bad_c, bad_a, bad_h, found;
        int          len;

        vecs[0].img  = '{16'h1280, 16'h1140, 16'hFFFF, 16'hFFFF};
        vecs[0].n    = 2;
        vecs[0].expv = '{17'h11280, 17'h11140, 17'h0, 17'h0};
        vecs[1].img  = '{16'hFFFF, 16'h1111, 16'h2222, 16'hFFFF};
        vecs[1].n    = 0;
        vecs[1].expv = '{17'h0, 17'h0, 17'h0, 17'h0};
        vecs[2].img  = '{16'hF0F0, 16'h3A04, 16'hFFFF, 16'hFFFF};
        vecs[2].n    = 2;
        vecs[2].expv = '{17'h1F0F0, 17'h13A04, 17'h0, 17'h0};
        vecs[3].img  = '{16'h0102, 16'h0304, 16'h0506, 16'hFFFF};
        vecs[3].n    = 3;
        vecs[3].expv = '{17'h10102, 17'h10304, 17'h10506, 17'h0};

        rst            = 1'b1;
        start          = 1'b0;
        host_cmd       = 17'h0;
        host_cmd_valid = 1'b0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven walks with fixed ready and a 10-cycle response.
        for (int v = 0; v < 4; v++) begin
            clear_rom();
            for (int j = 0; j < 4; j++) rom[j] = vecs[v].img[j];
            exp_q.delete();
            for (int j = 0; j < vecs[v].n; j++) exp_q.push_back(vecs[v].expv[j]);
            ready_mode = 0;
            resp_delay = 10;
            pulse_start();
            wait_done(-1);
            check_log("tbl");
        end

        // Randomized walks: random ready, delay, contents and an ignored mid-walk start.
        for (int it = 0; it < 12; it++) begin
            clear_rom();
            len = $urandom_range(0, 24);
            for (int i = 0; i < len; i++) begin
                rom[i] = 16'($urandom);
                if (rom[i] == 16'hFFFF) rom[i] = 16'h1234;
                if ($urandom_range(0, 5) == 0) rom[i] = 16'hF0F0;
            end
            ready_mode = 1;
            resp_delay = $urandom_range(0, 6);
            build_model();
            pulse_start();
            wait_done($urandom_range(2, 30));
            check_log("rnd");
        end

        // Stall in ISSUE: command must hold, no advance, host locked out.
        clear_rom();
        rom[0]     = 16'h5566;
        ready_mode = 2;
        resp_delay = 3;
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rw_cmd_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("stall_valid_seen", 32'(found), 32'h1);
        chk("stall_busy", 32'(busy), 32'h1);
        cmd0           = rw_cmd;
        a0             = rom_addr;
        host_cmd       = 17'h1ABCD;
        host_cmd_valid = 1'b1;
        bad_v = 1'b0; bad_c = 1'b0; bad_a = 1'b0; bad_h = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!rw_cmd_valid)    bad_v = 1'b1;
            if (rw_cmd !== cmd0)  bad_c = 1'b1;
            if (rom_addr !== a0)  bad_a = 1'b1;
            if (host_cmd_ready)   bad_h = 1'b1;
        end
        chk("stall_cmd", 32'(cmd0), 32'h15566);
        chk("stall_valid_drop", 32'(bad_v), 32'h0);
        chk("stall_cmd_change", 32'(bad_c), 32'h0);
        chk("stall_addr_move", 32'(bad_a), 32'h0);
        chk("stall_host_rdy", 32'(bad_h), 32'h0);
        chk("stall_no_hs", 32'(hs_log.size()), 32'h0);
        host_cmd_valid = 1'b0;
        ready_mode     = 0;
        wait_done(-1);
        build_model();
        check_log("stall");

        // Host passthrough read after done.
        mem[8'h0A] = 8'h76;
        resp_delay = 3;
        @(posedge clk);
        #1;
        hs_log.delete();
        host_cmd       = 17'h00A00;
        host_cmd_valid = 1'b1;
        @(negedge clk);
        chk("host_fwd_valid", 32'(rw_cmd_valid), 32'h1);
        chk("host_fwd_cmd", 32'(rw_cmd), 32'h00A00);
        chk("host_rdy", 32'(host_cmd_ready), 32'h1);
        @(posedge clk);
        #1;
        host_cmd_valid = 1'b0;
        chk("host_hs_cnt", 32'(hs_log.size()), 32'h1);
        if (hs_log.size() > 0) chk("host_hs_cmd", 32'(hs_log[0]), 32'h00A00);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rw_resp_valid) begin
                found = 1'b1;
                chk("host_resp_early", 32'(host_resp_valid), 32'h0);
                break;
            end
        end
        chk("host_resp_seen", 32'(found), 32'h1);
        @(negedge clk);
        chk("host_resp_vld", 32'(host_resp_valid), 32'h1);
        chk("host_resp", 32'(host_resp), 32'h00A76);
        @(negedge clk);
        chk("host_resp_pulse", 32'(host_resp_valid), 32'h0);
        @(posedge clk);
        #1;
        ready_mode = 2;
        @(posedge clk);
        #1;
        host_cmd_valid = 1'b1;
        @(negedge clk);
        chk("host_rdy_follow", 32'(host_cmd_ready), 32'h0);
        chk("host_valid_follow", 32'(rw_cmd_valid), 32'h1);
        host_cmd_valid = 1'b0;
        ready_mode     = 0;

        // Reset while waiting for a response, then restart.
        clear_rom();
        rom[0]     = 16'h1234;
        resp_delay = 30;
        @(posedge clk);
        #1;
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (hs_log.size() == 1) begin
                found = 1'b1;
                break;
            end
        end
        chk("midrst_hs_seen", 32'(found), 32'h1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check_reset("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        resp_delay = 2;
        @(posedge clk);
        #1;
        pulse_start();
        chk("restart_addr", 32'(rom_addr), 32'h0);
        wait_done(-1);
        build_model();
        check_log("restart");

        // Full table, no terminator: all 256 entries written, then done.
        for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i)};
        resp_delay = 0;
        ready_mode = 0;
        build_model();
        pulse_start();
        wait_done(-1);
        check_log("wrap");

`ifdef CAM_INIT_VERIFY_EN
        // Readback always wrong: 1 write + 3 retries, 4 errors, then advance.
        clear_rom();
        rom[0]     = 16'h3A04;
        rom[1]     = 16'h0B0C;
        rd_zero    = 1'b1;
        resp_delay = 2;
        pulse_start();
        wait_done(-1);
        rd_zero = 1'b0;
        split_log();
        chk("vfy_nwr", 32'(wr_q.size()), 32'd8);
        for (int i = 0; i < 4 && i < wr_q.size(); i++) chk("vfy_wr", 32'(wr_q[i]), 32'h13A04);
        chk("vfy_nrd", 32'(rd_q.size()), 32'd8);
        for (int i = 0; i < 4 && i < rd_q.size(); i++) chk("vfy_rd", 32'(rd_q[i]), 32'h03A00);
        if (wr_q.size() > 4) chk("vfy_advance", 32'(wr_q[4]), 32'h10B0C);
        chk("vfy_err_cnt", 32'(err_cnt), 32'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
